alu_op_issue: RTL and testbench
===============================

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width.
REQ-002 Parameter OPCODE_LENGTH, default 4, width of Operation code driven to the ALU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  upstream presents a decoded-instruction transaction.
REQ-006 in_ready  output  1  block accepts a transaction this cycle.
REQ-007 in_opcode  input  7  instruction opcode field [6:0].
REQ-008 in_funct3  input  3  instruction funct3 field.
REQ-009 in_funct7  input  7  instruction funct7 field.
REQ-010 in_srcA, in_srcB  input  DATA_WIDTH each  operand values.
REQ-011 out_valid  output  1  Operation/SrcA/SrcB hold a valid ALU request.
REQ-012 out_ready  input  1  ALU-side consumer takes the request this cycle.
REQ-013 Operation  output  OPCODE_LENGTH  ALU operation code.
REQ-014 SrcA, SrcB  output  DATA_WIDTH each  ALU operands.
REQ-015 illegal_pulse  output  1  one-cycle pulse: an unsupported instruction was accepted.
REQ-016 illegal_count  output  8  saturating count of accepted illegal instructions.

Function
REQ-017 Input handshake: transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-018 Decode: opcode 0110011, funct7 0000000: funct3 000->0010 (ADD), 111->0000 (AND), 110->0001 (OR), 100->1001 (XOR); any other funct3/funct7 -> illegal.
REQ-019 Decode: opcode 0010011 (funct7 ignored): funct3 000->0010, 111->0000, 110->0001, 100->1001; other funct3 -> illegal.
REQ-020 Decode: opcode 0000011 or 0100011 -> 0010 (address ADD), funct3/funct7 ignored.
REQ-021 Decode: opcode 1100011 funct3 000 (BEQ) -> 1000 (Equal); other funct3 -> illegal.
REQ-022 Decode: any other opcode -> illegal.
REQ-023 Legal accepted transaction: Operation code plus in_srcA/in_srcB captured unmodified into the buffer.
REQ-024 Illegal accepted transaction: consumed (handshake completes), not buffered, never appears at the output; illegal_pulse=1 in the following cycle; illegal_count increments, saturating at 255.
REQ-025 Buffer: two entries (output register MAIN, skid register SKID); FIFO order strictly preserved.
REQ-026 States: EMPTY (none valid), ONE (MAIN valid), TWO (MAIN and SKID valid).
REQ-027 in_ready=1 in EMPTY and ONE, 0 in TWO; in_ready is a function of registered state only (no combinational path from out_ready or in_valid).
REQ-028 out_valid=1 exactly in ONE and TWO; Operation/SrcA/SrcB always reflect MAIN.
REQ-029 EMPTY + legal accept -> ONE, MAIN loaded.
REQ-030 ONE + legal accept, no drain -> TWO, SKID loaded; ONE + legal accept + drain -> ONE, MAIN reloaded with new entry.
REQ-031 ONE + drain, no legal accept -> EMPTY.
REQ-032 TWO + drain -> ONE, SKID moved to MAIN; TWO without drain -> TWO, outputs held stable.
REQ-033 Illegal accept never changes buffer state; concurrent drain still applies.
REQ-034 Latency: legal transaction accepted at edge N with MAIN empty or draining at N is on the outputs with out_valid=1 after edge N (one cycle).
REQ-035 While out_valid=1 and out_ready=0, Operation/SrcA/SrcB SHALL not change.
REQ-036 When out_valid=0, Operation/SrcA/SrcB hold their last value (no requirement to zero).

Reset
REQ-037 On reset=0, immediately (asynchronously): state EMPTY, out_valid=0, Operation=0000, SrcA=0, SrcB=0, illegal_pulse=0, illegal_count=0; in_ready=1 after reset.
REQ-038 Reset asserted mid-operation discards all buffered entries; no transfer completes while reset=0.
REQ-039 Release of reset is sampled synchronously; first accept is possible on the first rising edge with reset=1.

Verification
REQ-040 Reset, then R-type ADD (opcode 0110011, f3 000, f7 0), A=5, B=7, out_ready=1 -> next cycle out_valid=1, Operation=0010, SrcA=5, SrcB=7.
REQ-041 out_ready=0, send ANDI then BEQ back-to-back -> after 2nd accept in_ready=0, outputs hold 0000; raise out_ready -> 0000 then 1000 in order, state returns EMPTY.
REQ-042 Opcode 1111111 accepted -> no out_valid, illegal_pulse=1 one cycle, illegal_count=1; 300 illegal accepts -> illegal_count=255.
REQ-043 Full throughput: in_valid=1 and out_ready=1 continuously for 10 legal LW/SW -> 10 outputs on 10 consecutive cycles, Operation=0010 each, in_ready never drops.
REQ-044 State TWO, assert reset=0 between edges -> out_valid=0, Operation=0000, illegal_count=0 immediately; after release next accepted XOR (f3 100) emerges as 1001.
REQ-045 R-type funct7 0100000 (SUB) -> treated illegal, illegal_count increments, no output.

Source files
------------

// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes an instruction's opcode/funct3/funct7 into an ALU
// operation code and issues {Operation, SrcA, SrcB} through a two-entry
// buffer. The buffer is an output register (MAIN) plus a skid register (SKID).
// Unsupported instructions are consumed without being issued. Each one
// raises a one-cycle pulse and bumps a saturating counter.
module alu_op_issue #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic        [6:0]               in_opcode,
  input  logic        [2:0]               in_funct3,
  input  logic        [6:0]               in_funct7,
  input  logic signed [DATA_WIDTH-1:0]    in_srcA,
  input  logic signed [DATA_WIDTH-1:0]    in_srcB,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic        [OPCODE_LENGTH-1:0] Operation,
  output logic signed [DATA_WIDTH-1:0]    SrcA,
  output logic signed [DATA_WIDTH-1:0]    SrcB,
  output logic                            illegal_pulse,
  output logic        [7:0]               illegal_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Returns {legal, code}. The ALU codes are AND=0000, OR=0001, ADD=0010,
  // EQUAL=1000 and XOR=1001. When the instruction is not supported, the
  // result is all zeros with the legal bit clear.
  function automatic logic [4:0] decode_op(input logic [6:0] opc,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
    logic [4:0] alu;
    logic [4:0] r;
    case (f3)
      3'b000:  alu = 5'b1_0010;
      3'b111:  alu = 5'b1_0000;
      3'b110:  alu = 5'b1_0001;
      3'b100:  alu = 5'b1_1001;
      default: alu = 5'b0_0000;
    endcase
    case (opc)
      7'b0110011:             r = (f7 == 7'b0000000) ? alu : 5'b0_0000;
      7'b0010011:             r = alu;
      7'b0000011, 7'b0100011: r = 5'b1_0010;
      7'b1100011:             r = (f3 == 3'b000) ? 5'b1_1000 : 5'b0_0000;
      default:                r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Counter that sticks at its maximum value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t                            state;
  logic                              legal_p0;
  logic        [3:0]                 code_p0;
  logic                              accept;
  logic                              push;
  logic                              bad;
  logic                              drain;
  logic                              skid_load;
  logic        [OPCODE_LENGTH-1:0]   main_op_p1;
  logic signed [DATA_WIDTH-1:0]      main_a_p1;
  logic signed [DATA_WIDTH-1:0]      main_b_p1;
  logic        [OPCODE_LENGTH-1:0]   skid_op_p1;
  logic signed [DATA_WIDTH-1:0]      skid_a_p1;
  logic signed [DATA_WIDTH-1:0]      skid_b_p1;

  // ---- stage p0: decode and handshake qualification ----
  assign {legal_p0, code_p0} = decode_op(in_opcode, in_funct3, in_funct7);

  // in_ready depends only on the state register, so there is no
  // combinational path from out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal_p0;
  assign bad       = accept & ~legal_p0;
  assign drain     = out_valid & out_ready;
  assign skid_load = (state == ONE) & push & ~drain;

  // ---- stage p1: MAIN/SKID buffer ----
  // Buffer FSM. MAIN drives the outputs directly, and the illegal-instruction
  // bookkeeping is updated alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= EMPTY;
      main_op_p1    <= '0;
      main_a_p1     <= '0;
      main_b_p1     <= '0;
      illegal_pulse <= 1'b0;
      illegal_count <= 8'd0;
    end else begin
      illegal_pulse <= bad;
      if (bad) begin
        illegal_count <= sat_inc8(illegal_count);
      end
      case (state)
        EMPTY: begin
          if (push) begin
            main_op_p1 <= OPCODE_LENGTH'(code_p0);
            main_a_p1  <= in_srcA;
            main_b_p1  <= in_srcB;
            state      <= ONE;
          end
        end
        ONE: begin
          if (push) begin
            if (drain) begin
              main_op_p1 <= OPCODE_LENGTH'(code_p0);
              main_a_p1  <= in_srcA;
              main_b_p1  <= in_srcB;
            end else begin
              state <= TWO;
            end
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_op_p1 <= skid_op_p1;
            main_a_p1  <= skid_a_p1;
            main_b_p1  <= skid_b_p1;
            state      <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // SKID is data only. It is written when a second entry arrives while
  // MAIN is stalled, and it is read only in state TWO.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_op_p1 <= OPCODE_LENGTH'(code_p0);
      skid_a_p1  <= in_srcA;
      skid_b_p1  <= in_srcB;
    end
  end

  assign Operation = main_op_p1;
  assign SrcA      = main_a_p1;
  assign SrcB      = main_b_p1;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed scenarios plus randomized traffic for
// alu_op_issue. A queue-based reference model predicts the outputs.
module tb_alu_op_issue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_srcA;
  logic [31:0] in_srcB;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        illegal_pulse;
  logic [7:0]  illegal_count;

  int checks = 0;
  int errors = 0;

  alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_srcA(in_srcA), .in_srcB(in_srcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .illegal_pulse(illegal_pulse), .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of pending requests (at most two).
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  ent_t q[$];
  ent_t last_shown;
  int   exp_cnt;
  bit   exp_pulse;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operation code for a supported instruction, or -1 if unsupported.
  function automatic int alu_code(input logic [2:0] f3);
    if (f3 == 3'd0) return 2;
    if (f3 == 3'd7) return 0;
    if (f3 == 3'd6) return 1;
    if (f3 == 3'd4) return 9;
    return -1;
  endfunction

  function automatic int ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    if (opc == 7'b0110011) return (f7 == 7'd0) ? alu_code(f3) : -1;
    if (opc == 7'b0010011) return alu_code(f3);
    if (opc == 7'b0000011 || opc == 7'b0100011) return 2;
    if (opc == 7'b1100011) return (f3 == 3'd0) ? 8 : -1;
    return -1;
  endfunction

  task automatic model_clear();
    q.delete();
    last_shown = '0;
    exp_cnt    = 0;
    exp_pulse  = 1'b0;
  endtask

  task automatic check_outputs();
    ent_t e;
    e = (q.size() > 0) ? q[0] : last_shown;
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    check("Operation", Operation, e.op);
    check("SrcA", SrcA, e.a);
    check("SrcB", SrcB, e.b);
    check("illegal_pulse", illegal_pulse, exp_pulse);
    check("illegal_count", illegal_count, exp_cnt);
  endtask

  // Advance the model by one rising edge, using the inputs currently driven.
  task automatic model_step();
    bit   acc;
    bit   drn;
    int   op;
    ent_t n;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    op  = ref_op(in_opcode, in_funct3, in_funct7);
    if (drn) last_shown = q.pop_front();
    exp_pulse = acc && (op < 0);
    if (acc && op < 0 && exp_cnt < 255) exp_cnt++;
    if (acc && op >= 0) begin
      n.op = 4'(op);
      n.a  = in_srcA;
      n.b  = in_srcB;
      q.push_back(n);
    end
  endtask

  // Drive one cycle: apply inputs, check at the falling edge, then advance.
  task automatic cyc(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic ordy);
    in_valid  = v;
    in_opcode = opc;
    in_funct3 = f3;
    in_funct7 = f7;
    in_srcA   = a;
    in_srcB   = b;
    out_ready = ordy;
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0, ordy);
  endtask

  // Assert reset between edges and check the immediate effect. Then hold
  // reset across an edge with a legal request offered, and release it.
  task automatic async_reset();
    #2;
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_opcode = 7'b0110011;
    in_funct3 = 3'd0;
    in_funct7 = 7'd0;
    out_ready = 1'b1;
    #1;
    model_clear();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_Operation", Operation, 4'd0);
    check("rst_SrcA", SrcA, 32'd0);
    check("rst_SrcB", SrcB, 32'd0);
    check("rst_illegal_count", illegal_count, 8'd0);
    check("rst_illegal_pulse", illegal_pulse, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    reset    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] opc_tab [7];
    logic [6:0] opc;
    logic [6:0] f7;
    int         k;
    opc_tab[0] = 7'b0110011; opc_tab[1] = 7'b0010011; opc_tab[2] = 7'b0000011;
    opc_tab[3] = 7'b0100011; opc_tab[4] = 7'b1100011; opc_tab[5] = 7'b1111111;
    opc_tab[6] = 7'b0110111;

    reset = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_srcA = '0; in_srcB = '0; out_ready = 1'b0;
    model_clear();
    #2;
    check("init_out_valid", out_valid, 1'b0);
    check("init_Operation", Operation, 4'd0);
    check("init_illegal_count", illegal_count, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // R-type ADD with one-cycle latency
    cyc(1'b1, 7'b0110011, 3'b000, 7'd0, 32'd5, 32'd7, 1'b1);
    check("add_valid", out_valid, 1'b1);
    check("add_op", Operation, 4'b0010);
    check("add_a", SrcA, 32'd5);
    check("add_b", SrcB, 32'd7);
    idle(1'b1);

    // ANDI then BEQ into a stalled consumer, then drain in order
    cyc(1'b1, 7'b0010011, 3'b111, 7'h55, 32'd11, 32'd12, 1'b0);
    cyc(1'b1, 7'b1100011, 3'b000, 7'd0, 32'd21, 32'd22, 1'b0);
    check("two_in_ready", in_ready, 1'b0);
    check("two_op", Operation, 4'b0000);
    idle(1'b0);
    idle(1'b1);
    check("drain2_op", Operation, 4'b1000);
    idle(1'b1);
    idle(1'b1);

    // Illegal opcode, then saturation of the counter
    cyc(1'b1, 7'b1111111, 3'd0, 7'd0, 32'd1, 32'd2, 1'b1);
    check("ill_pulse", illegal_pulse, 1'b1);
    check("ill_count1", illegal_count, 8'd1);
    check("ill_no_valid", out_valid, 1'b0);
    for (int i = 0; i < 299; i++) cyc(1'b1, 7'b1111111, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
    idle(1'b1);
    check("ill_sat", illegal_count, 8'd255);

    // SUB is not supported; the saturated counter must stay put
    cyc(1'b1, 7'b0110011, 3'b000, 7'b0100000, 32'd3, 32'd4, 1'b1);
    check("sub_pulse", illegal_pulse, 1'b1);
    check("sub_no_valid", out_valid, 1'b0);
    idle(1'b1);

    // Full throughput with loads and stores
    for (int i = 0; i < 10; i++)
      cyc(1'b1, (i % 2) ? 7'b0100011 : 7'b0000011, 3'($urandom), 7'($urandom),
          $urandom, $urandom, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to TWO, reset asynchronously, then issue XOR
    cyc(1'b1, 7'b0010011, 3'b110, 7'd0, 32'd31, 32'd32, 1'b0);
    cyc(1'b1, 7'b0000011, 3'b010, 7'd0, 32'd41, 32'd42, 1'b0);
    check("pre_rst_in_ready", in_ready, 1'b0);
    async_reset();
    cyc(1'b1, 7'b0110011, 3'b100, 7'd0, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1);
    check("xor_op", Operation, 4'b1001);
    check("xor_valid", out_valid, 1'b1);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k   = $urandom_range(0, 7);
      opc = (k == 7) ? 7'($urandom) : opc_tab[k];
      f7  = ($urandom_range(0, 3) < 2) ? 7'd0 :
            (($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom));
      cyc(($urandom_range(0, 9) < 7), opc, 3'($urandom), f7, $urandom, $urandom,
          ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
